mem_bus_arbiter: RTL and testbench

//   Two-master arbiter/sequencer in front of the multi-cycle, ack-handshaked data RAM.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_watchdog.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory bus arbiter
//
// Purpose: FSM state encoding, bus-owner encoding and grant vector constants
//          used by mem_bus_arbiter.
// Ports:   none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - clear/enable cycle counter with terminal flag
//
// Purpose: counts enabled cycles since the last clear and raises expired once
//          the count reaches TIMEOUT; the count then holds until cleared.
// Ports:
//   clk      in  posedge clock
//   rst      in  synchronous active-high reset
//   clear    in  restart count at zero
//   enable   in  advance count this cycle
//   expired  out count == TIMEOUT
module arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter/sequencer for the ack-handshaked data RAM
//
// Purpose: shares the RAM between the fetch port (I) and the load/store port (D).
//          A granted request is latched and held on the RAM until mem_ack (or a
//          watchdog timeout), the result is returned with a one-cycle ready pulse,
//          then the bus is parked until the RAM drops ack.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_req/i_addr                    fetch request and address
//   i_rdata/i_ready/i_stall         fetch data, completion pulse, stall
//   d_req/d_we/d_addr/d_wdata       load/store request
//   d_rdata/d_ready/d_stall         load data, completion pulse, stall
//   mem_cs/mem_we/mem_addr/mem_din  registered RAM command
//   mem_dout/mem_ack                RAM read data and done handshake
//   grant                           01=I, 10=D, 00=none
//   bus_err                         one-cycle pulse on timeout
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                TIMEOUT   = 15,
  parameter logic [ADDR_W-1:0] PARK_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_ack,
  output logic [1:0]        grant,
  output logic              bus_err
);

  state_t state, state_nxt;
  owner_t owner, owner_nxt;
  owner_t last_owner, last_owner_nxt;
  owner_t pick;

  logic              mem_cs_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_din_nxt;
  logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt, rd_val;
  logic              i_ready_nxt, d_ready_nxt, bus_err_nxt;
  logic [1:0]        grant_nxt;
  logic              wd_clear, wd_enable, wd_expired;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  assign i_stall = i_req & ~i_ready;
  assign d_stall = d_req & ~d_ready;

  // Round robin: on a tie the port that did not own the last acked transfer wins.
  always_comb begin
    pick = OWNER_I;
    if (i_req && d_req) begin
      pick = (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
    end else if (d_req) begin
      pick = OWNER_D;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    mem_cs_nxt     = mem_cs;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_din_nxt    = mem_din;
    grant_nxt      = grant;
    i_rdata_nxt    = i_rdata;
    d_rdata_nxt    = d_rdata;
    i_ready_nxt    = 1'b0;
    d_ready_nxt    = 1'b0;
    bus_err_nxt    = 1'b0;
    wd_clear       = 1'b0;
    wd_enable      = 1'b0;
    rd_val         = '0;

    unique case (state)
      ST_IDLE: begin
        mem_cs_nxt   = 1'b0;
        mem_we_nxt   = 1'b0;
        mem_addr_nxt = PARK_ADDR;
        grant_nxt    = GRANT_NONE;
        wd_clear     = 1'b1;
        // A stale ack from the previous transfer must never complete a new one.
        if ((i_req || d_req) && !mem_ack) begin
          owner_nxt  = pick;
          mem_cs_nxt = 1'b1;
          state_nxt  = ST_BUSY;
          if (pick == OWNER_D) begin
            mem_we_nxt   = d_we;
            mem_addr_nxt = d_addr;
            mem_din_nxt  = d_wdata;
            grant_nxt    = GRANT_D;
          end else begin
            mem_we_nxt   = 1'b0;
            mem_addr_nxt = i_addr;
            mem_din_nxt  = '0;
            grant_nxt    = GRANT_I;
          end
        end
      end

      ST_BUSY: begin
        wd_enable = 1'b1;
        // Ack takes priority over a timeout sampled in the same cycle.
        if (mem_ack || wd_expired) begin
          rd_val = (mem_ack && !mem_we) ? mem_dout : '0;
          if (owner == OWNER_I) begin
            i_ready_nxt = 1'b1;
            i_rdata_nxt = rd_val;
          end else begin
            d_ready_nxt = 1'b1;
            d_rdata_nxt = rd_val;
          end
          bus_err_nxt = !mem_ack;
          if (mem_ack) begin
            last_owner_nxt = owner;
          end
          mem_cs_nxt   = 1'b0;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = PARK_ADDR;
          grant_nxt    = GRANT_NONE;
          state_nxt    = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (!mem_ack) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWNER_I;
      last_owner <= OWNER_I;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= PARK_ADDR;
      mem_din    <= '0;
      grant      <= GRANT_NONE;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      mem_cs     <= mem_cs_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_din    <= mem_din_nxt;
      grant      <= grant_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      i_ready    <= i_ready_nxt;
      d_ready    <= d_ready_nxt;
      bus_err    <= bus_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
//
// Purpose: directed scenarios plus a randomized two-port traffic phase checked
//          against a transaction-level model (round-robin order, shadow memory).
// Ports:   none (top-level bench).
module tb_mem_bus_arbiter;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ready, d_ready, i_stall, d_stall;
  logic        mem_cs, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [1:0]  grant;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  // RAM environment: ack after ack_delay stable cycles of a selected address.
  logic [31:0] ram [16];
  logic [31:0] shadow [16];
  logic [31:0] last_addr;
  int          stable;
  int          ack_delay;
  bit          ack_force;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .grant(grant), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return (a < 32'd16) ? shadow[a[3:0]] : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_addr !== last_addr) stable = 0;
    else stable++;
    last_addr = mem_addr;
    mem_ack  = ((mem_cs === 1'b1) && (stable >= ack_delay)) || ack_force;
    mem_dout = (mem_addr < 32'd16) ? ram[mem_addr[3:0]] : 32'd0;
    if (mem_ack && mem_cs && mem_we && (mem_addr < 32'd16)) ram[mem_addr[3:0]] = mem_din;
    chk("both_ready", 32'(i_ready & d_ready), 32'd0);
    chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    chk("i_stall", 32'(i_stall), 32'(i_req & ~i_ready));
    chk("d_stall", 32'(d_stall), 32'(d_req & ~d_ready));
  endtask

  // who: 0 = I completed, 1 = D completed, -1 = budget expired
  task automatic wait_ready(input int budget, output int who, output int n);
    who = -1;
    n = 0;
    while (who < 0 && n < budget) begin
      tick();
      n++;
      if (i_ready) who = 0;
      else if (d_ready) who = 1;
    end
    chk("ready_seen", 32'(who >= 0), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cs"}, 32'(mem_cs), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'hFFFF_FFFF);
    chk({tag, "_din"}, mem_din, 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_rdy"}, 32'({i_ready, d_ready}), 32'd0);
    chk({tag, "_rdata"}, i_rdata | d_rdata, 32'd0);
    chk({tag, "_err"}, 32'(bus_err), 32'd0);
  endtask

  initial begin
    int who, n, model_last, exp_who;
    bit pend [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic        p_we [2];
    logic [31:0] exp_data;
    bit seen;

    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_dout = 0; last_addr = 32'hFFFF_FFFF; stable = 0;
    ack_delay = 8; ack_force = 0;
    for (int k = 0; k < 16; k++) begin
      ram[k] = $urandom;
      shadow[k] = ram[k];
    end
    ram[3] = 32'hDEAD_BEEF;
    shadow[3] = 32'hDEAD_BEEF;

    tick(); tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // 1: single load, address/request changes mid-BUSY are ignored
    d_req = 1; d_we = 0; d_addr = 3;
    tick(); tick(); tick();
    chk("t1_grant", 32'(grant), 32'b10);
    chk("t1_cs", 32'(mem_cs), 32'd1);
    chk("t1_addr", mem_addr, 32'd3);
    d_req = 0; d_addr = 7; d_wdata = 32'h5555_AAAA;
    wait_ready(50, who, n);
    chk("t1_who", who, 1);
    chk("t1_latency", n + 3, 10);
    chk("t1_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("t1_err", 32'(bus_err), 32'd0);
    tick();
    chk("t1_pulse", 32'(d_ready), 32'd0);
    chk("t1_park", mem_addr, 32'hFFFF_FFFF);
    tick();

    // 2: store then load same address; held-high ack blocks the next grant
    d_req = 1; d_we = 1; d_addr = 5; d_wdata = 32'h1234_5678;
    wait_ready(50, who, n);
    chk("t2_st_who", who, 1);
    chk("t2_st_rdata", d_rdata, 32'd0);
    shadow[5] = 32'h1234_5678;
    d_we = 0;
    ack_force = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_wait_grant", 32'({grant, mem_cs}), 32'd0);
    end
    ack_force = 0;
    wait_ready(50, who, n);
    chk("t2_ld_who", who, 1);
    chk("t2_ld_rdata", d_rdata, 32'h1234_5678);
    d_req = 0;
    tick(); tick();

    // 3: fresh reset, both ports held -> D, I, D, I
    rst = 1; tick(); rst = 0; tick();
    i_req = 1; i_addr = 1; d_req = 1; d_we = 0; d_addr = 2;
    for (int k = 0; k < 4; k++) begin
      exp_who = (k % 2 == 0) ? 1 : 0;
      wait_ready(50, who, n);
      chk("t3_order", who, exp_who);
      if (exp_who == 1) chk("t3_d_rdata", d_rdata, shadow[2]);
      else chk("t3_i_rdata", i_rdata, shadow[1]);
      if (k == 3) begin i_req = 0; d_req = 0; end
    end
    tick(); tick(); tick();

    // 4a: ack arrives exactly at the timeout cycle -> ack wins
    ack_delay = T;
    i_req = 1; i_addr = 4;
    wait_ready(50, who, n);
    chk("t4a_who", who, 0);
    chk("t4a_latency", n, T + 2);
    chk("t4a_rdata", i_rdata, shadow[4]);
    chk("t4a_err", 32'(bus_err), 32'd0);
    i_req = 0;
    tick(); tick();
    // 4b: no ack at all -> timeout
    ack_delay = 1000;
    i_req = 1; i_addr = 6;
    wait_ready(50, who, n);
    chk("t4b_who", who, 0);
    chk("t4b_latency", n, T + 2);
    chk("t4b_err", 32'(bus_err), 32'd1);
    chk("t4b_rdata", i_rdata, 32'd0);
    i_req = 0;
    ack_delay = 8;
    tick();
    chk("t4b_err_pulse", 32'({bus_err, i_ready}), 32'd0);
    i_req = 1;
    wait_ready(50, who, n);
    chk("t4c_latency", n, 10);
    chk("t4c_rdata", i_rdata, shadow[6]);
    i_req = 0;
    tick(); tick();

    // 5: reset in BUSY cycle 4 aborts the store
    d_req = 1; d_we = 1; d_addr = 9; d_wdata = 32'hAAAA_5555;
    for (int k = 0; k < 5; k++) tick();
    rst = 1; d_req = 0; d_we = 0;
    tick();
    check_reset_values("t5");
    rst = 0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (i_ready || d_ready) seen = 1;
    end
    chk("t5_no_ready", 32'(seen), 32'd0);
    d_req = 1; d_addr = 9;
    wait_ready(50, who, n);
    chk("t5_fresh_who", who, 1);
    chk("t5_fresh_latency", n, 10);
    chk("t5_fresh_rdata", d_rdata, ram[9] === shadow[9] ? shadow[9] : 32'hx);
    d_req = 0;
    model_last = 1;

    // Randomized two-port traffic against the transaction model
    pend[0] = 0; pend[1] = 0;
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) != 0)) pend[p] = 1;
        else if (!pend[p]) continue;
        else continue;
        p_addr[p]  = ($urandom_range(0, 7) == 0) ? 32'h0000_1000 + $urandom_range(0, 255)
                                                 : 32'($urandom_range(0, 15));
        p_we[p]    = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        p_wdata[p] = $urandom;
      end
      if (!pend[0] && !pend[1]) begin
        pend[1] = 1; p_addr[1] = 32'($urandom_range(0, 15)); p_we[1] = 0; p_wdata[1] = 0;
      end
      if (pend[0]) begin i_req = 1; i_addr = p_addr[0]; end
      if (pend[1]) begin d_req = 1; d_we = p_we[1]; d_addr = p_addr[1]; d_wdata = p_wdata[1]; end
      exp_who = (pend[0] && pend[1]) ? (model_last == 0 ? 1 : 0) : (pend[0] ? 0 : 1);
      exp_data = p_we[exp_who] ? 32'd0 : model_read(p_addr[exp_who]);
      wait_ready(60, who, n);
      chk("rand_owner", who, exp_who);
      chk("rand_err", 32'(bus_err), 32'd0);
      if (exp_who == 0) begin
        chk("rand_i_rdata", i_rdata, exp_data);
        i_req = 0;
      end else begin
        chk("rand_d_rdata", d_rdata, exp_data);
        d_req = 0;
        if (p_we[1] && p_addr[1] < 32'd16) shadow[p_addr[1][3:0]] = p_wdata[1];
      end
      pend[exp_who] = 0;
      model_last = exp_who;
    end
    i_req = 0; d_req = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
